// File: rtl/proc_sequencer_if.sv
// Instruction-memory and datapath bus between the sequencer and its surroundings.
// Memory contract: instruction returns mem[instruction_addr] one cycle after the address is sampled.
interface proc_sequencer_if;
    logic [31:0] instruction_addr;
    logic [31:0] instruction;
    logic [31:0] t1;
    logic [31:0] ir;
    logic        reg_w;

    modport master (
        output instruction_addr,
        output ir,
        output reg_w,
        input  instruction,
        input  t1
    );

    modport slave (
        input  instruction_addr,
        input  ir,
        input  reg_w,
        output instruction,
        output t1
    );
endinterface

// File: rtl/proc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/LOAD/EXEC/WB per instruction, with
// single-step, HALT opcode and restart-from-HALT; pc and retire count wrap mod 2^32.
module proc_sequencer (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    step,
    proc_sequencer_if.master        bus,
    output logic                    busy,
    output logic                    halted,
    output logic [31:0]             instr_count,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    localparam logic [4:0] OP_HALT = 5'b11111;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] count_q, count_d;

    logic        ir_b;
    logic        ir_w;
    logic [4:0]  ir_op;

    assign ir_b  = ir_q[31];
    assign ir_w  = ir_q[30];
    assign ir_op = ir_q[28:24];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= 32'd0;
            ir_q    <= 32'd0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    // start only matters in IDLE/HALT; while busy it is simply never looked at.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        count_d     = count_q;
        bus.reg_w   = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                busy    = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                busy    = 1'b1;
                ir_d    = bus.instruction;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_d = (ir_op == OP_HALT) ? S_HALT : S_WB;
            end
            S_WB: begin
                busy      = 1'b1;
                bus.reg_w = ir_w;
                // t1 is a two's-complement offset; plain 32-bit add gives the wrap.
                pc_d      = ir_b ? (pc_q + bus.t1) : (pc_q + 32'd1);
                count_d   = count_q + 32'd1;
                state_d   = step ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_d    = 32'd0;
                    count_d = 32'd0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.instruction_addr = pc_q;
    assign bus.ir               = ir_q;
    assign instr_count          = count_q;
    assign dbg_state            = state_q;

    a_reg_w_only_in_wb : assert property (@(posedge clk) bus.reg_w |-> (state_q == S_WB));
    a_busy_halt_excl   : assert property (@(posedge clk) !(busy && halted));

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: directed scenarios plus random programs, checked
// cycle by cycle against an instruction-level reference model.
module tb_proc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        busy;
    logic        halted;
    logic [31:0] instr_count;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    proc_sequencer_if bus();

    proc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .step        (step),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- environment: memory and datapath ----------------
    logic [31:0] mem [0:255];

    function automatic logic [31:0] datapath(input logic [31:0] w);
        if (w[29]) return {{16{w[15]}}, w[15:0]};
        return {16'h0000, w[15:0]};
    endfunction

    function automatic logic [31:0] mk(input logic b, input logic w, input logic i,
                                       input logic [4:0] op, input logic [15:0] imm);
        return {b, w, i, op, 8'h00, imm};
    endfunction

    localparam logic [31:0] HALT_W = {3'b000, 5'b11111, 24'h000000};

    always @(posedge clk) bus.instruction <= mem[bus.instruction_addr[7:0]];
    assign bus.t1 = datapath(bus.ir);

    // ---------------- reference model ----------------
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_LOAD = 2, PH_EXEC = 3, PH_WB = 4, PH_HALT = 5;
    int          m_phase;
    logic [31:0] m_pc, m_ir, m_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] last_cnt = 32'd0;

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
        return w[31] ? pc + datapath(w) : pc + 32'd1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= PH_IDLE;
            m_pc    <= 32'd0;
            m_ir    <= 32'd0;
            m_cnt   <= 32'd0;
            exp_q.delete();
        end else begin
            case (m_phase)
                PH_IDLE:  if (start) m_phase <= PH_FETCH;
                PH_FETCH: m_phase <= PH_LOAD;
                PH_LOAD: begin
                    m_ir    <= bus.instruction;
                    m_phase <= PH_EXEC;
                end
                PH_EXEC:  m_phase <= (m_ir[28:24] == 5'h1F) ? PH_HALT : PH_WB;
                PH_WB: begin
                    m_pc    <= next_pc(m_pc, m_ir);
                    m_cnt   <= m_cnt + 32'd1;
                    exp_q.push_back(next_pc(m_pc, m_ir));
                    m_phase <= step ? PH_IDLE : PH_FETCH;
                end
                PH_HALT: if (start) begin
                    m_pc    <= 32'd0;
                    m_cnt   <= 32'd0;
                    m_phase <= PH_FETCH;
                end
                default: m_phase <= PH_IDLE;
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("addr",   bus.instruction_addr, m_pc);
            check("ir",     bus.ir, m_ir);
            check("reg_w",  {31'd0, bus.reg_w}, {31'd0, (m_phase == PH_WB) && m_ir[30]});
            check("busy",   {31'd0, busy}, {31'd0, (m_phase >= PH_FETCH) && (m_phase <= PH_WB)});
            check("halted", {31'd0, halted}, {31'd0, m_phase == PH_HALT});
            check("count",  instr_count, m_cnt);
            // retire scoreboard: each increment must land on the predicted next pc
            if (instr_count == last_cnt + 32'd1) begin
                if (exp_q.size() == 0) check("sb_depth", 32'(exp_q.size()), 32'd1);
                else check("retire_pc", bus.instruction_addr, exp_q.pop_front());
            end
            last_cnt <= instr_count;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; step = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_halted(input string tag, input int budget);
        int k = 0;
        while (!halted && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((busy || halted) && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, busy || halted}, 32'd0);
    endtask

    task automatic fill_halt();
        for (int a = 0; a < 256; a++) mem[a] = HALT_W;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fill_halt();
        do_reset();
        mon_en = 1'b1;
        check("rst_addr",  bus.instruction_addr, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_halt",  {31'd0, halted}, 32'd0);
        tick(3);
        check("idle_stays", {31'd0, busy}, 32'd0);

        // sequential run: add w=1 then HALT
        mem[0] = mk(1'b0, 1'b1, 1'b1, 5'h01, 16'h0000);
        mem[1] = HALT_W;
        pulse_start();
        check("seq_c1_busy", {31'd0, busy}, 32'd1);
        tick(3);
        check("seq_c4_regw", {31'd0, bus.reg_w}, 32'd1);
        tick(1);
        check("seq_c5_addr", bus.instruction_addr, 32'd1);
        wait_halted("seq_halt_to", 20);
        check("seq_count", instr_count, 32'd1);

        // restart from HALT with start held while busy; branch +5 then -1
        mem[0] = mk(1'b1, 1'b0, 1'b0, 5'h02, 16'd5);
        mem[5] = mk(1'b1, 1'b0, 1'b1, 5'h03, 16'hFFFF);
        mem[4] = HALT_W;
        mem[1] = HALT_W;
        start = 1'b1;
        tick(1);
        check("rs_addr",   bus.instruction_addr, 32'd0);
        check("rs_count",  instr_count, 32'd0);
        check("rs_halted", {31'd0, halted}, 32'd0);
        check("rs_busy",   {31'd0, busy}, 32'd1);
        tick(4);
        check("br_addr5", bus.instruction_addr, 32'd5);
        check("br_cnt1",  instr_count, 32'd1);
        start = 1'b0;
        wait_halted("br_halt_to", 20);
        check("br_pc4",   bus.instruction_addr, 32'd4);
        check("br_cnt2",  instr_count, 32'd2);

        // single step
        do_reset();
        mem[0] = mk(1'b0, 1'b1, 1'b0, 5'h01, 16'h0000);
        mem[1] = mk(1'b0, 1'b0, 1'b0, 5'h04, 16'h0000);
        mem[2] = HALT_W;
        step = 1'b1;
        pulse_start();
        wait_idle("ss1_idle_to", 10);
        check("ss1_pc",  bus.instruction_addr, 32'd1);
        check("ss1_cnt", instr_count, 32'd1);
        pulse_start();
        check("ss2_addr", bus.instruction_addr, 32'd1);
        wait_idle("ss2_idle_to", 10);
        check("ss2_pc",  bus.instruction_addr, 32'd2);
        step = 1'b0;
        pulse_start();
        wait_halted("ss_halt_to", 10);

        // reset in WB of a w=1 instruction
        do_reset();
        mem[0] = mk(1'b0, 1'b1, 1'b0, 5'h01, 16'h0000);
        pulse_start();
        tick(3);
        check("mr_regw_wb", {31'd0, bus.reg_w}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mr_addr", bus.instruction_addr, 32'd0);
        check("mr_regw", {31'd0, bus.reg_w}, 32'd0);
        check("mr_cnt",  instr_count, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);

        // pc wrap: branch to 0xFFFFFFFF, then a plain instruction there
        mem[0]   = mk(1'b1, 1'b0, 1'b1, 5'h02, 16'hFFFF);
        mem[255] = mk(1'b0, 1'b1, 1'b0, 5'h01, 16'h1234);
        pulse_start();
        tick(4);
        check("wr_addr_max", bus.instruction_addr, 32'hFFFF_FFFF);
        tick(4);
        check("wr_addr_0", bus.instruction_addr, 32'd0);
        tick(2);
        do_reset();

        // random programs and control traffic
        for (int a = 0; a < 256; a++) begin
            if ($urandom_range(0, 15) == 0) mem[a] = HALT_W;
            else if ($urandom_range(0, 1) == 1)
                mem[a] = mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'b1,
                            5'($urandom_range(0, 30)), 16'($signed($urandom_range(0, 16)) - 8));
            else
                mem[a] = mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'b0,
                            5'($urandom_range(0, 30)), 16'($urandom_range(0, 16)));
        end
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            step  = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0; start = 1'b0; step = 1'b0;
        tick(2);
        @(negedge clk);
        #1;
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the instruction memory, register file and ALU.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  run request, sampled only in IDLE or HALT.
REQ-005 step  input  1  single-step mode, sampled in WB.
REQ-006 instruction  input  32  instruction memory read data, valid one cycle after instruction_addr is sampled.
REQ-007 t1  input  32  datapath result (alu_out when i=1, else zero-extended imm).
REQ-008 instruction_addr  output  32  current pc, driven to the instruction memory.
REQ-009 ir  output  32  latched instruction word, fed to the decoder.
REQ-010 reg_w  output  1  register file write strobe.
REQ-011 busy  output  1  high in FETCH, LOAD, EXEC and WB.
REQ-012 halted  output  1  high in HALT.
REQ-013 instr_count  output  32  count of retired instructions.

Function
REQ-014 Instruction field encoding: b=ir[31], w=ir[30], i=ir[29], op=ir[28:24]; op=5'b11111 is HALT.
REQ-015 FSM states: IDLE, FETCH, LOAD, EXEC, WB, HALT; one state per cycle, so 4 cycles per non-halt instruction.
REQ-016 IDLE: start=1 -> FETCH with pc unchanged; start=0 -> stay in IDLE.
REQ-017 FETCH: instruction_addr=pc; memory samples it at end of cycle; next state LOAD.
REQ-018 LOAD: ir <= instruction at end of cycle; next state EXEC.
REQ-019 EXEC: reg_w=0; ALU operands settle; op=5'b11111 -> HALT, with pc, instr_count and registers unchanged; otherwise -> WB.
REQ-020 WB actions:
- reg_w=ir[30] for exactly this cycle.
- pc <= pc + t1 when ir[31]=1, else pc <= pc + 1.
- instr_count <= instr_count + 1.
REQ-021 WB next state: step=1 -> IDLE; step=0 -> FETCH.
REQ-022 HALT: halted=1; start=1 -> FETCH with pc <= 0, instr_count <= 0 and halted cleared next cycle.
REQ-023 start is ignored while busy=1; no effect, no latching.
REQ-024 reg_w is never high outside WB.
REQ-025 pc arithmetic is 32-bit modulo: t1 acts as a two's-complement offset, and 0xFFFFFFFF+1 wraps to 0.
REQ-026 instr_count wraps from 0xFFFFFFFF to 0.
REQ-027 ir holds its value in every state except LOAD.
REQ-028 A branch with t1=0 leaves pc unchanged, so the same instruction re-executes; this is legal and not detected.

Reset
REQ-029 On rst=1 at a clock edge, the following are loaded:
- state=IDLE; pc=0; ir=0; instr_count=0.
- reg_w=0, busy=0, halted=0.
REQ-030 rst overrides all other inputs in any state; a reset during WB suppresses that cycle's pc update and count increment but does not retract the reg_w already asserted in that cycle; reg_w is 0 from the following cycle.
REQ-031 After reset the block stays in IDLE until start=1.

Verification
REQ-032 Sequential run:
- Stimulus: rst, then start pulse; mem[0]=add with w=1, mem[1]=HALT.
- Response: busy on cycles 1-4; reg_w high only on cycle 4; instruction_addr=1 at cycle 5; halted=1 after EXEC of mem[1]; instr_count=1.
REQ-033 Branch:
- Stimulus: mem[0] with b=1, t1=5.
- Response: instruction_addr=5 in the FETCH following WB; instr_count=1.
- Stimulus: t1=0xFFFFFFFF from pc=5.
- Response: pc=4.
REQ-034 Single-step:
- Stimulus: step=1, start pulse.
- Response: one instruction executes and the FSM returns to IDLE with pc=1.
- Stimulus: second start.
- Response: execution resumes at pc=1.
REQ-035 Restart from HALT:
- Stimulus: start in HALT.
- Response: pc=0, instr_count=0, halted=0, FETCH next cycle.
- Stimulus: start held high while busy.
- Response: no change to sequencing.
REQ-036 Reset mid-operation:
- Stimulus: rst asserted in WB of a w=1 instruction.
- Response: next cycle IDLE, pc=0, reg_w=0, instr_count=0.
REQ-037 Wrap:
- Stimulus: pc preloaded via branch to 0xFFFFFFFF, non-branch instruction.
- Response: next FETCH at instruction_addr=0.
